// File: rtl/spi_bus_arbiter.sv
// Round-robin owner of a shared SPI byte engine: grants one requester, drives its CS,
// sequences one engine start per byte and enforces a CS-high gap between transactions.
module spi_bus_arbiter #(
    parameter int NumReq      = 3,
    parameter int data_width  = 8,
    parameter int LenWidth    = 13,
    parameter int SetupCycles = 2,
    parameter int GapCycles   = 4
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic [NumReq-1:0]              req_i,
    input  logic [NumReq*LenWidth-1:0]     len_i,
    input  logic [NumReq*data_width-1:0]   tx_data_i,
    output logic [NumReq-1:0]              gnt_o,
    output logic                           tx_ready_o,
    output logic [data_width-1:0]          rx_data_o,
    output logic [NumReq-1:0]              rx_valid_o,
    output logic [NumReq-1:0]              done_o,
    output logic [NumReq-1:0]              cs_no,
    output logic                           eng_start_o,
    output logic [data_width-1:0]          eng_tx_o,
    input  logic                           eng_done_i,
    input  logic [data_width-1:0]          eng_rx_i
);
    localparam int IdxW = $clog2(NumReq);
    localparam int SW   = $clog2(SetupCycles + 1);
    localparam int GW   = $clog2(GapCycles + 1);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_START, S_WAIT, S_GAP} state_t;

    state_t                state;
    logic [IdxW-1:0]       last, cur, win_idx;
    logic                  win_found;
    logic [LenWidth-1:0]   cnt, win_len;
    logic [SW-1:0]         sc;
    logic [GW-1:0]         gc;
    logic [NumReq-1:0]     win_oh, cur_oh;
    logic [data_width-1:0] cur_tx;

    // Search starts just after the previous winner so every requester gets a turn.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 1; i <= NumReq; i++) begin
            if (!win_found && req_i[(int'(last) + i) % NumReq]) begin
                win_found = 1'b1;
                win_idx   = IdxW'((int'(last) + i) % NumReq);
            end
        end
    end

    assign win_len = len_i[int'(win_idx)*LenWidth +: LenWidth];
    assign win_oh  = NumReq'(1) << win_idx;
    assign cur_oh  = NumReq'(1) << cur;
    assign cur_tx  = tx_data_i[int'(cur)*data_width +: data_width];

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state       <= S_IDLE;
            gnt_o       <= '0;
            rx_valid_o  <= '0;
            done_o      <= '0;
            eng_start_o <= 1'b0;
            tx_ready_o  <= 1'b0;
            cs_no       <= '1;
            rx_data_o   <= '0;
            eng_tx_o    <= '0;
            last        <= IdxW'(NumReq - 1);
            cur         <= '0;
            cnt         <= '0;
            sc          <= '0;
            gc          <= '0;
        end else begin
            rx_valid_o  <= '0;
            done_o      <= '0;
            eng_start_o <= 1'b0;
            tx_ready_o  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (win_found) begin
                        cur  <= win_idx;
                        last <= win_idx;
                        cnt  <= win_len;
                        // Zero-length requests complete immediately without touching the bus.
                        if (win_len == '0) begin
                            done_o <= win_oh;
                        end else begin
                            gnt_o <= win_oh;
                            cs_no <= ~win_oh;
                            sc    <= '0;
                            state <= S_SETUP;
                        end
                    end
                end
                S_SETUP: begin
                    if (int'(sc) == SetupCycles - 1) begin
                        eng_start_o <= 1'b1;
                        tx_ready_o  <= 1'b1;
                        eng_tx_o    <= cur_tx;
                        state       <= S_START;
                    end else begin
                        sc <= sc + SW'(1);
                    end
                end
                S_START: state <= S_WAIT;
                S_WAIT: begin
                    if (eng_done_i) begin
                        rx_data_o  <= eng_rx_i;
                        rx_valid_o <= cur_oh;
                        cnt        <= cnt - LenWidth'(1);
                        if (cnt > LenWidth'(1)) begin
                            eng_start_o <= 1'b1;
                            tx_ready_o  <= 1'b1;
                            eng_tx_o    <= cur_tx;
                            state       <= S_START;
                        end else begin
                            gnt_o  <= '0;
                            cs_no  <= '1;
                            done_o <= cur_oh;
                            gc     <= '0;
                            state  <= S_GAP;
                        end
                    end
                end
                S_GAP: begin
                    if (int'(gc) == GapCycles - 1) state <= S_IDLE;
                    else                           gc    <= gc + GW'(1);
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Directed bench for spi_bus_arbiter: one task per scenario, inline checks against
// hand-derived cycle numbers (cycle k = observation just after the k-th edge following stimulus).
module tb_spi_bus_arbiter;
    localparam int N = 3, DW = 8, LW = 13, SC = 2, GC = 4;

    logic              clk = 1'b0;
    logic              reset_i;
    logic [N-1:0]      req_i;
    logic [N*LW-1:0]   len_i;
    logic [N*DW-1:0]   tx_data_i;
    logic [N-1:0]      gnt_o, rx_valid_o, done_o, cs_no;
    logic              tx_ready_o, eng_start_o, eng_done_i;
    logic [DW-1:0]     rx_data_o, eng_tx_o, eng_rx_i;

    int errors = 0;
    int checks = 0;
    int eng_dly, eng_cnt;
    logic [7:0] eng_rx_base;

    always #5 clk = ~clk;

    spi_bus_arbiter #(.NumReq(N), .data_width(DW), .LenWidth(LW),
                      .SetupCycles(SC), .GapCycles(GC)) dut (
        .clk_i(clk), .reset_i(reset_i), .req_i(req_i), .len_i(len_i),
        .tx_data_i(tx_data_i), .gnt_o(gnt_o), .tx_ready_o(tx_ready_o),
        .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .done_o(done_o),
        .cs_no(cs_no), .eng_start_o(eng_start_o), .eng_tx_o(eng_tx_o),
        .eng_done_i(eng_done_i), .eng_rx_i(eng_rx_i));

    task automatic tick;
        @(posedge clk); #1;
    endtask

    // Engine model: done pulse sampled 5 edges after the edge that launched the start.
    task automatic eng_step;
        eng_done_i = 1'b0;
        if (eng_start_o) eng_dly = 4;
        else if (eng_dly > 0) begin
            eng_dly--;
            if (eng_dly == 0) begin
                eng_done_i = 1'b1;
                eng_rx_i   = eng_rx_base + 8'(eng_cnt);
                eng_cnt++;
            end
        end
    endtask

    task automatic do_reset;
        reset_i = 1'b0; req_i = '0; len_i = '0; tx_data_i = '0;
        eng_done_i = 1'b0; eng_rx_i = '0; eng_dly = 0; eng_cnt = 0; eng_rx_base = '0;
        tick; tick;
        reset_i = 1'b1;
    endtask

    task automatic test_reset;
        do_reset;
        reset_i = 1'b0;
        tick;
        checks++;
        if ({gnt_o, rx_valid_o, done_o, eng_start_o, tx_ready_o} !== '0) begin
            errors++;
            $display("FAIL reset_pulses got %b want 0", {gnt_o, rx_valid_o, done_o, eng_start_o, tx_ready_o});
        end
        checks++;
        if ({cs_no, rx_data_o, eng_tx_o} !== {3'b111, 8'h00, 8'h00}) begin
            errors++;
            $display("FAIL reset_cs_data got %h want %h", {cs_no, rx_data_o, eng_tx_o}, {3'b111, 16'h0});
        end
        reset_i = 1'b1;
        tick;
        checks++;
        if (gnt_o !== '0 || cs_no !== 3'b111 || done_o !== '0) begin
            errors++;
            $display("FAIL reset_idle gnt=%b cs=%b done=%b want 000 111 000", gnt_o, cs_no, done_o);
        end
    endtask

    task automatic test_single;
        int cyc_gnt, cyc_start, cyc_done, n_start, n_rx, n_done;
        do_reset;
        eng_rx_base = 8'hA1;
        len_i[0 +: LW] = 13'd3; tx_data_i[0 +: DW] = 8'h50; req_i = 3'b001;
        cyc_gnt = -1; cyc_start = -1; cyc_done = -1; n_start = 0; n_rx = 0; n_done = 0;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            tick; eng_step;
            if (gnt_o != '0) begin
                req_i = '0;
                if (cyc_gnt < 0) cyc_gnt = cyc;
                checks++;
                if (cs_no !== 3'b110 || gnt_o !== 3'b001) begin
                    errors++;
                    $display("FAIL single_cs cyc %0d cs=%b gnt=%b want 110 001", cyc, cs_no, gnt_o);
                end
            end
            if (eng_start_o) begin
                checks++;
                if (eng_tx_o !== 8'(8'h50 + n_start) || tx_ready_o !== 1'b1) begin
                    errors++;
                    $display("FAIL single_tx got %h rdy=%b want %h rdy=1", eng_tx_o, tx_ready_o, 8'(8'h50 + n_start));
                end
                if (cyc_start < 0) cyc_start = cyc;
                n_start++;
                tx_data_i[0 +: DW] = 8'(8'h50 + n_start);
            end
            if (rx_valid_o != '0) begin
                checks++;
                if (rx_valid_o !== 3'b001 || rx_data_o !== 8'(8'hA1 + n_rx)) begin
                    errors++;
                    $display("FAIL single_rx vld=%b data=%h want 001 %h", rx_valid_o, rx_data_o, 8'(8'hA1 + n_rx));
                end
                n_rx++;
            end
            if (done_o != '0) begin
                n_done++; cyc_done = cyc;
            end
            if (cyc_done > 0 && cyc > cyc_done && cyc <= cyc_done + GC) begin
                checks++;
                if (cs_no !== 3'b111 || gnt_o !== '0) begin
                    errors++;
                    $display("FAIL single_gap cyc %0d cs=%b gnt=%b want 111 000", cyc, cs_no, gnt_o);
                end
            end
        end
        checks++;
        if (cyc_gnt != 1 || cyc_start != 3) begin
            errors++;
            $display("FAIL single_latency gnt@%0d start@%0d want 1 3", cyc_gnt, cyc_start);
        end
        checks++;
        if (n_start != 3 || n_rx != 3 || n_done != 1 || cyc_done != 18) begin
            errors++;
            $display("FAIL single_counts starts=%0d rx=%0d done=%0d done@%0d want 3 3 1 18", n_start, n_rx, n_done, cyc_done);
        end
    endtask

    task automatic test_fairness;
        int ng;
        logic [N-1:0] prev_gnt, prev_owner;
        do_reset;
        len_i[0 +: LW] = 13'd1; len_i[LW +: LW] = 13'd1; len_i[2*LW +: LW] = 13'd1;
        req_i = 3'b111;
        ng = 0; prev_gnt = '0; prev_owner = '0;
        for (int cyc = 1; cyc <= 200 && ng < 6; cyc++) begin
            tick; eng_step;
            if (gnt_o != '0 && prev_gnt == '0) begin
                checks++;
                if (gnt_o !== 3'(1 << (ng % 3)) || gnt_o === prev_owner) begin
                    errors++;
                    $display("FAIL fair_order grant %0d got %b want %b prev %b", ng, gnt_o, 3'(1 << (ng % 3)), prev_owner);
                end
                prev_owner = gnt_o;
                ng++;
            end
            prev_gnt = gnt_o;
        end
        checks++;
        if (ng != 6) begin
            errors++;
            $display("FAIL fair_timeout grants %0d want 6", ng);
        end
    endtask

    task automatic test_zero_len;
        do_reset;
        len_i[LW +: LW] = 13'd0; req_i = 3'b010;
        tick;
        checks++;
        if (done_o !== 3'b010 || gnt_o !== '0 || cs_no !== 3'b111 || eng_start_o !== 1'b0) begin
            errors++;
            $display("FAIL zero_done done=%b gnt=%b cs=%b start=%b want 010 000 111 0", done_o, gnt_o, cs_no, eng_start_o);
        end
        len_i[0 +: LW] = 13'd1; len_i[2*LW +: LW] = 13'd1; req_i = 3'b101;
        tick;
        checks++;
        if (gnt_o !== 3'b100 || cs_no !== 3'b011 || done_o !== '0 || eng_start_o !== 1'b0) begin
            errors++;
            $display("FAIL zero_next gnt=%b cs=%b done=%b start=%b want 100 011 000 0", gnt_o, cs_no, done_o, eng_start_o);
        end
    endtask

    task automatic test_mid_reset;
        int n_start;
        do_reset;
        eng_rx_base = 8'hB1;
        len_i[0 +: LW] = 13'd4; tx_data_i[0 +: DW] = 8'h33; req_i = 3'b001;
        n_start = 0;
        for (int cyc = 1; cyc <= 40 && n_start < 2; cyc++) begin
            tick; eng_step;
            if (eng_start_o) n_start++;
        end
        req_i = '0;
        tick; tick;
        reset_i = 1'b0;
        tick;
        checks++;
        if ({gnt_o, rx_valid_o, done_o, eng_start_o, tx_ready_o} !== '0 || cs_no !== 3'b111 ||
            rx_data_o !== 8'h00 || eng_tx_o !== 8'h00) begin
            errors++;
            $display("FAIL midrst_outputs gnt=%b vld=%b done=%b cs=%b rx=%h tx=%h want reset values",
                     gnt_o, rx_valid_o, done_o, cs_no, rx_data_o, eng_tx_o);
        end
        reset_i = 1'b1; eng_done_i = 1'b1; eng_rx_i = 8'hEE;
        tick;
        eng_done_i = 1'b0;
        checks++;
        if (rx_valid_o !== '0 || done_o !== '0 || gnt_o !== '0) begin
            errors++;
            $display("FAIL midrst_stray vld=%b done=%b gnt=%b want 000", rx_valid_o, done_o, gnt_o);
        end
        tick;
        checks++;
        if (rx_valid_o !== '0 || rx_data_o !== 8'h00 || eng_start_o !== 1'b0) begin
            errors++;
            $display("FAIL midrst_after vld=%b rx=%h start=%b want 000 00 0", rx_valid_o, rx_data_o, eng_start_o);
        end
    endtask

    task automatic test_churn;
        int n_rx0, cyc_done, cyc_g2;
        do_reset;
        eng_rx_base = 8'hD0;
        len_i[0 +: LW] = 13'd2; len_i[2*LW +: LW] = 13'd1; req_i = 3'b001;
        n_rx0 = 0; cyc_done = -1; cyc_g2 = -1;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            tick; eng_step;
            if (eng_start_o && req_i[0]) req_i[0] = 1'b0;
            if (cyc == 5) req_i[2] = 1'b1;
            if (rx_valid_o[0]) n_rx0++;
            if (done_o[0]) cyc_done = cyc;
            if (gnt_o[2]) begin
                cyc_g2 = cyc;
                checks++;
                if (cs_no !== 3'b011 || gnt_o !== 3'b100) begin
                    errors++;
                    $display("FAIL churn_grant2 cs=%b gnt=%b want 011 100", cs_no, gnt_o);
                end
                break;
            end
        end
        checks++;
        if (n_rx0 != 2 || cyc_done != 13) begin
            errors++;
            $display("FAIL churn_owner rx=%0d done@%0d want 2 13", n_rx0, cyc_done);
        end
        checks++;
        if (cyc_g2 - cyc_done != GC + 1) begin
            errors++;
            $display("FAIL churn_gap grant2@%0d done@%0d want gap %0d", cyc_g2, cyc_done, GC + 1);
        end
    endtask

    task automatic test_spurious;
        int n_start, n_rx, cyc_done, gap_probe;
        do_reset;
        eng_rx_base = 8'hC0;
        eng_done_i = 1'b1; eng_rx_i = 8'h77;
        tick;
        eng_done_i = 1'b0;
        checks++;
        if (rx_valid_o !== '0 || rx_data_o !== 8'h00 || gnt_o !== '0) begin
            errors++;
            $display("FAIL spur_idle vld=%b rx=%h gnt=%b want 000 00 000", rx_valid_o, rx_data_o, gnt_o);
        end
        len_i[0 +: LW] = 13'd2; req_i = 3'b001;
        n_start = 0; n_rx = 0; cyc_done = -1; gap_probe = -10;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            tick; eng_step;
            if (cyc == 1) begin
                req_i = '0; eng_done_i = 1'b1; eng_rx_i = 8'h77;
            end
            if (cyc == 2) begin
                checks++;
                if (rx_valid_o !== '0) begin
                    errors++;
                    $display("FAIL spur_setup vld=%b want 000", rx_valid_o);
                end
            end
            if (cyc == gap_probe + 1) begin
                checks++;
                if (rx_valid_o !== '0 || eng_start_o !== 1'b0 || rx_data_o !== 8'hC1) begin
                    errors++;
                    $display("FAIL spur_gap vld=%b start=%b rx=%h want 000 0 c1", rx_valid_o, eng_start_o, rx_data_o);
                end
            end
            if (eng_start_o) n_start++;
            if (rx_valid_o[0]) n_rx++;
            if (done_o[0]) begin
                cyc_done = cyc; gap_probe = cyc;
                eng_done_i = 1'b1; eng_rx_i = 8'h77;
            end
        end
        checks++;
        if (n_start != 2 || n_rx != 2 || cyc_done != 13) begin
            errors++;
            $display("FAIL spur_counts starts=%0d rx=%0d done@%0d want 2 2 13", n_start, n_rx, cyc_done);
        end
    endtask

    initial begin
        reset_i = 1'b0; req_i = '0; len_i = '0; tx_data_i = '0;
        eng_done_i = 1'b0; eng_rx_i = '0; eng_dly = 0; eng_cnt = 0; eng_rx_base = '0;
        test_reset;
        test_single;
        test_fairness;
        test_zero_len;
        test_mid_reset;
        test_churn;
        test_spurious;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/spi_bus_arbiter.md
# spi_bus_arbiter

Round-robin arbiter and transaction sequencer that shares one SPI byte engine among up to `NumReq` peripheral clients (Ethernet, DAC, ADC) inside `main_6502`. It grants the engine to one requester at a time and drives that requester's chip select. It then issues one engine start per byte for the requested length and returns received bytes to the owner. Chip selects are released and a programmable gap is enforced between transactions.

## Interface
- `NumReq`, 3: number of requesters, 2..8.
- `data_width`, 8: SPI byte width.
- `LenWidth`, 13: width of per-transaction byte count.
- `SetupCycles`, 2: clocks from CS low to first engine start, ≥1.
- `GapCycles`, 4: clocks CS held high after a transaction, ≥1.

Ports:
- `clk_i` in 1: system clock. Single clock domain.
- `reset_i` in 1: reset, synchronous and active-low.
- `req_i` in NumReq: per-requester transaction request, level.
- `len_i` in NumReq*LenWidth: packed byte counts. Slice k belongs to requester k.
- `tx_data_i` in NumReq*data_width: packed next TX byte per requester.
- `gnt_o` out NumReq: one-hot grant, high for the whole transaction.
- `tx_ready_o` out 1: pulse, current TX byte of the granted requester consumed.
- `rx_data_o` out data_width: last received byte.
- `rx_valid_o` out NumReq: one-hot pulse, `rx_data_o` valid for that requester.
- `done_o` out NumReq: one-hot pulse, transaction finished.
- `cs_no` out NumReq: active-low chip selects.
- `eng_start_o` out 1: one-cycle start pulse to the byte engine.
- `eng_tx_o` out data_width: byte to the engine, valid with `eng_start_o`.
- `eng_done_i` in 1: engine byte-complete pulse.
- `eng_rx_i` in data_width: engine RX byte, valid with `eng_done_i`.

## Operation
- States: IDLE, SETUP, START, WAIT, GAP.
- **IDLE**
  - If any `req_i` is high, select the winner round-robin. Search starts at `last+1` mod NumReq, where `last` is the previous winner (reset value NumReq-1, so requester 0 wins first).
  - Latch the winner index and `len` into a byte counter. Set `last`.
  - If the latched len is 0: pulse `done_o[k]` next cycle, no grant and no CS, stay in IDLE. The round-robin pointer still advances.
  - Otherwise assert `gnt_o[k]` and `cs_no[k]`=0 and go to SETUP.
- **SETUP**
  - Count SetupCycles clocks, then go to START.
- **START**
  - Pulse `eng_start_o`, with `eng_tx_o` = `tx_data_i` slice k, and pulse `tx_ready_o` in the same cycle. Go to WAIT.
- **WAIT**
  - On `eng_done_i`, register `eng_rx_i` into `rx_data_o` and pulse `rx_valid_o[k]` the next cycle. Decrement the counter.
  - If the counter was >1, return to START the next cycle.
  - Otherwise drop `gnt_o` and `cs_no[k]`, pulse `done_o[k]`, and go to GAP.
- **GAP**
  - All CS high for GapCycles clocks, then IDLE.
- Only requests sampled in IDLE are considered. `req_i` changes during SETUP/START/WAIT/GAP have no effect, and a grant runs to completion even if `req_i[k]` drops.
- `len_i`/`tx_data_i` slices of non-granted requesters are ignored.
- `eng_done_i` outside WAIT is ignored.
- Counters are LenWidth bits; max transaction 2^LenWidth−1 bytes, with no wrap.

## Timing
- Reset values (reset_i=0 sampled at an edge):
  - state IDLE.
  - `gnt_o`, `rx_valid_o`, `done_o`, `eng_start_o`, `tx_ready_o` = 0.
  - `cs_no` = all ones; `rx_data_o`, `eng_tx_o` = 0.
  - `last` = NumReq−1.
- Reset mid-transaction aborts within that cycle: CS high, grant dropped, no `done_o`. A late `eng_done_i` after reset is ignored.
- Request-to-grant latency: `req_i` high at edge N gives `gnt_o`/`cs_no` registered at edge N+1.
- First `eng_start_o` at edge N+1+SetupCycles.
- `eng_done_i` at edge M gives `rx_valid_o` at M+1, and either the next `eng_start_o` or `done_o` at M+1.
- Minimum time between two grants: GapCycles+1 clocks after `done_o`.
- All outputs are registered. Pulses are exactly one clock wide.

## Test plan
- **Single request:** NumReq=3; req_i=001, len=3, engine done 5 clocks after each start with rx 0xA1/0xA2/0xA3. Required:
  - cs_no=110 for the whole transaction.
  - 3 eng_start_o pulses with tx_data echoed.
  - rx_valid_o[0] pulses carrying those bytes in order.
  - done_o[0] once, then CS high for 4 clocks.
- **Fairness:** all req_i held high, len=1 each. Grant order is 0,1,2,0,1,2, with no requester granted twice in a row.
- **Zero length:** req_i=010, len=0. done_o[1] pulses, cs_no stays 111, eng_start_o never pulses, and the next grant goes to requester 2 when it is requesting.
- **Mid-transfer reset:** len=4, reset_i low during WAIT of byte 2. Next clock: all outputs at reset values, no done_o. A stray eng_done_i afterward gives no rx_valid_o.
- **Request churn:** requester 0 granted len=2 and drops req_i after the first start; requester 2 raises req_i during WAIT. Requester 0 still receives 2 bytes and done_o[0], and requester 2 is granted GapCycles+1 clocks after.
- **Spurious engine done:** eng_done_i pulsed in IDLE/SETUP/GAP produces no rx_valid_o and no counter change.
